uart_tx_serial: RTL

//  Serialising UART transmitter; sits directly downstream of the APB strobe/byte controller.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/uart_tx_serial.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial UART transmitter.
//   uart_state_t : frame sequencer states (idle, start bit, data bits, parity bit, stop bits)
//   PARITY_*     : encodings of the PARITY parameter
//   clog2_min1   : $clog2 that never returns 0, for sizing counters that hold at least one bit
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter.
//   clk       : clock, all updates on posedge
//   rst_n     : asynchronous active-low reset, counter to 0
//   clear     : synchronous restart of the bit period (frame launch)
//   enable    : count while a frame is in flight; holds at 0 otherwise
//   bit_tick  : high on the final clk of each bit period
//   near_tick : high on the clk just before bit_tick, so registered
//               outputs can be made to coincide with the final clk
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic near_tick
);
  import uart_pkg::*;

  localparam int            CW   = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= '0;
    end else if (enable) begin
      clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + 1'b1;
    end
  end

  assign bit_tick  = enable & (clk_cnt == LAST);
  assign near_tick = enable & (clk_cnt == NEAR);

endmodule

// File: rtl/uart_tx_serial.sv
// Serialising UART transmitter fed by a dv/done byte handshake.
// Frame: start bit (0), 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). A frame is launched by a rising edge of dv
// while idle; dv held high never retransmits.
//   clk     : clock, all updates on posedge
//   rst_n   : asynchronous active-low reset; aborts a frame, tx high at once
//   dv      : data valid; rising edge launches a frame
//   tx_data : byte to send, sampled in the dv rising-edge cycle
//   tx      : registered serial output, idle high
//   busy    : high from launch until the cycle after done
//   done    : one-cycle pulse on the final clk of the last stop bit
module uart_tx_serial #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dv,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import uart_pkg::*;

  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_serial: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serial: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serial: CLKS_PER_BIT must be at least 2");
  end

  localparam bit   HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic PAR_INIT   = (PARITY == PARITY_ODD);
  localparam logic STOP_LAST  = (STOP_BITS == 2);

  uart_state_t state;
  logic        dv_q;
  logic        armed;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic        par_acc;
  logic        launch;
  logic        cnt_en;
  logic        bit_tick;
  logic        near_tick;

  // armed is low only in the first cycle out of reset, so a dv that was
  // already high while reset was asserted is not mistaken for a fresh edge.
  assign launch = dv & ~dv_q & armed & (state == ST_IDLE);
  assign cnt_en = (state != ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (launch),
    .enable   (cnt_en),
    .bit_tick (bit_tick),
    .near_tick(near_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dv_q     <= 1'b0;
      armed    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
    end else begin
      dv_q  <= dv;
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              if (HAS_PARITY) begin
                state <= ST_PARITY;
                // shreg[0] is bit 7, not yet folded into the accumulator
                tx    <= par_acc ^ shreg[0];
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shreg shifts on this same edge, so the next bit is shreg[1]
              tx      <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          // set one clk early so the registered pulse lands on the final clk
          if (near_tick && stop_cnt == STOP_LAST) begin
            done <= 1'b1;
          end
          if (bit_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Byte shift register and running parity; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (launch) begin
      shreg   <= tx_data;
      par_acc <= PAR_INIT;
    end else if (state == ST_DATA && bit_tick) begin
      shreg   <= {1'b0, shreg[7:1]};
      par_acc <= par_acc ^ shreg[0];
    end
  end

endmodule
